// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, channel codes and the default
// sample width used by both the receiver and the transmitter.
package i2s_pkg;

   localparam int I2S_DATA_W = 16;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } rx_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Pad synchronizer for the I2S slave inputs: SYNC_STAGES flops per pad plus a
// previous-value register on BCK that yields a one-clk rise strobe.
module i2s_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic bck_pad,
   input  logic ws_pad,
   input  logic din_pad,
   output logic bck_rise,
   output logic ws,
   output logic din
);

   logic [SYNC_STAGES-1:0] bck_sr;
   logic [SYNC_STAGES-1:0] ws_sr;
   logic [SYNC_STAGES-1:0] din_sr;
   logic                   bck_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bck_sr   <= '0;
         ws_sr    <= '0;
         din_sr   <= '0;
         bck_prev <= 1'b0;
      end else begin
         bck_sr   <= {bck_sr[SYNC_STAGES-2:0], bck_pad};
         ws_sr    <= {ws_sr[SYNC_STAGES-2:0], ws_pad};
         din_sr   <= {din_sr[SYNC_STAGES-2:0], din_pad};
         bck_prev <= bck_sr[SYNC_STAGES-1];
      end
   end

   // All three pads see the same delay, so DIN and WS stay aligned to the strobe.
   assign bck_rise = bck_sr[SYNC_STAGES-1] & ~bck_prev;
   assign ws       = ws_sr[SYNC_STAGES-1];
   assign din      = din_sr[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCK/LRCK/DIN on clk and delivers stereo pairs
// through a valid/ready port. Left-justified capture is enabled by I2S_RX_LJ_EN.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W      = I2S_DATA_W,
   parameter int MAX_SLOT    = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              sys_rst_i,
`ifdef I2S_RX_LJ_EN
   input  logic              fmt_lj,
`endif
   input  logic              i2s_bck,
   input  logic              i2s_lrck,
   input  logic              i2s_din,
   output logic [DATA_W-1:0] out_left,
   output logic [DATA_W-1:0] out_right,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              sync_err,
   output logic              locked
);

   localparam int CNT_W = $clog2(MAX_SLOT + 1);
   localparam int IDX_W = $clog2(DATA_W);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t MAX_CNT  = cnt_t'(MAX_SLOT);
   localparam cnt_t DATA_CNT = cnt_t'(DATA_W);

   logic              bck_rise;
   logic              ws_s;
   logic              din_s;
   logic              lj;

   rx_state_t         state;
   logic              ws_prev;
   cnt_t              cnt;
   logic [DATA_W-1:0] shift_word;
   logic [DATA_W-1:0] left_word;
   logic [DATA_W-1:0] frame_left;
   logic [DATA_W-1:0] frame_right;
   logic              frame_done;

   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] fill_word;
   logic [DATA_W-1:0] fin_word;
   logic              ws_chg;
   cnt_t              cnt_inc;

`ifdef I2S_RX_LJ_EN
   assign lj = fmt_lj;
`else
   assign lj = 1'b0;
`endif

   i2s_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_pin_sync (
      .clk     (clk),
      .rst     (sys_rst_i),
      .bck_pad (i2s_bck),
      .ws_pad  (i2s_lrck),
      .din_pad (i2s_din),
      .bck_rise(bck_rise),
      .ws      (ws_s),
      .din     (din_s)
   );

   always_comb begin
      bit_idx   = IDX_W'(DATA_W - 1) - cnt[IDX_W-1:0];
      fill_word = shift_word;
      if (cnt < DATA_CNT) fill_word[bit_idx] = din_s;
      // In LJ mode the WS-change bit belongs to the new channel, not the old one.
      fin_word  = lj ? shift_word : fill_word;
      ws_chg    = (ws_s != ws_prev);
      cnt_inc   = (cnt == MAX_CNT) ? MAX_CNT : cnt + cnt_t'(1);
   end

   always_ff @(posedge clk or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state       <= HUNT;
         ws_prev     <= 1'b0;
         cnt         <= '0;
         shift_word  <= '0;
         left_word   <= '0;
         frame_left  <= '0;
         frame_right <= '0;
         frame_done  <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (bck_rise) begin
            ws_prev <= ws_s;
            if (ws_chg) begin
               if (lj) begin
                  shift_word <= {din_s, {(DATA_W-1){1'b0}}};
                  cnt        <= cnt_t'(1);
               end else begin
                  shift_word <= '0;
                  cnt        <= '0;
               end
               case (state)
                  HUNT: begin
                     if (ws_s == CH_LEFT) begin
                        state  <= LEFT;
                        locked <= 1'b1;
                     end
                  end
                  LEFT: begin
                     if (ws_s == CH_RIGHT) begin
                        left_word <= fin_word;
                        state     <= RIGHT;
                     end
                  end
                  RIGHT: begin
                     if (ws_s == CH_LEFT) begin
                        frame_left  <= left_word;
                        frame_right <= fin_word;
                        frame_done  <= 1'b1;
                        state       <= LEFT;
                     end
                  end
                  default: begin
                     state  <= HUNT;
                     locked <= 1'b0;
                  end
               endcase
            end else begin
               shift_word <= fill_word;
               if (cnt_inc == MAX_CNT && state != HUNT) begin
                  sync_err <= 1'b1;
                  cnt      <= '0;
                  state    <= HUNT;
                  locked   <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
         end
      end
   end

   // Handshake: a pair moves on any clk with out_valid && out_ready; the data
   // holds while out_valid is high, and a frame arriving while the held pair
   // is stalled is dropped with an overrun pulse.
   always_ff @(posedge clk or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         out_left  <= '0;
         out_right <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (frame_done) begin
            if (!out_valid || out_ready) begin
               out_left  <= frame_left;
               out_right <= frame_right;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver: captures BCK, LRCK (WS) and DIN driven by an external master (e.g. a PMOD I2S ADC) and delivers stereo sample pairs to fabric logic.
- All inputs are oversampled on the single system clock; the block creates no derived clocks.
- Sits on a PMOD beside the I2S output path, so captured audio can feed the DAC chain or the debug LEDs.

Parameters:
- DATA_W, 16: bits kept per channel, MSB-first, two's complement.
- MAX_SLOT, 64: BCK rising edges allowed per channel slot before sync is declared lost.
- SYNC_STAGES, 2: synchronizer flops on each pad input (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the BCK frequency.
- sys_rst_i  in  1  asynchronous, active-high reset.
- i2s_bck  in  1  bit clock pad.
- i2s_lrck  in  1  word select pad; 0 = left, 1 = right.
- i2s_din  in  1  serial data pad.
- out_left  out  DATA_W  left sample of the last completed frame.
- out_right  out  DATA_W  right sample of the last completed frame.
- out_valid  out  1  a sample pair is held on out_left/out_right.
- out_ready  in  1  consumer accepts the pair.
- overrun  out  1  one-clk pulse when a completed frame is dropped.
- sync_err  out  1  one-clk pulse when sync is lost.
- locked  out  1  high in states LEFT and RIGHT.

Behaviour:
- Reset (async) clears every flop:
  - all outputs 0; state HUNT;
  - shift words and bit counter 0;
  - synchronizers cleared, with ws_prev = 0.
- Input capture:
  - BCK, LRCK and DIN each pass through SYNC_STAGES flops.
  - A BCK rise is detected from the synchronized BCK versus its previous value.
  - On each detected rise ("edge"), the synchronized DIN and WS are sampled together.
- Per-edge rules, standard I2S (WS changes one BCK before the MSB):
  - If ws != ws_prev, this edge's DIN is the final slot bit of the previous channel. Store it if cnt < DATA_W, finalize that channel's word, then set cnt = 0 and clear the new channel's word.
  - Otherwise, if cnt < DATA_W, write DIN into word[DATA_W-1-cnt].
  - cnt increments and saturates at MAX_SLOT.
  - Bits beyond DATA_W are discarded.
  - Slots shorter than DATA_W leave the LSBs as zero, so the word is left-aligned.
- State machine:
  - HUNT: ignore data. On a WS 1->0 edge, go to LEFT. No output.
  - LEFT: on a WS 0->1 edge, latch the left word internally and go to RIGHT.
  - RIGHT: on a WS 1->0 edge, the frame is complete; go to LEFT.
  - LEFT/RIGHT: if cnt reaches MAX_SLOT, pulse sync_err, clear cnt and go to HUNT. Partial frames are never published.
- Output handshake:
  - On frame completion with out_valid = 0: load out_left/out_right and set out_valid on the next clk.
  - Latency is fixed: SYNC_STAGES + 2 clk after the BCK pad rise.
  - Transfer occurs on a clk with out_valid && out_ready. out_valid then clears unless a frame completes in the same clk; in that case the new pair loads and out_valid stays 1.
  - On frame completion with out_valid = 1 && !out_ready: drop the new frame, keep the held data, pulse overrun.
  - out_left and out_right are stable while out_valid is high.
- The first frame after reset or after sync_err is always discarded, because receive starts in HUNT.

Optional Feature:
- Macro I2S_RX_LJ_EN.
- Defined:
  - adds input port fmt_lj (1 bit);
  - when fmt_lj = 1, left-justified format: the edge where WS changes carries the MSB of the new channel. Finalize the previous channel first, then store DIN at word[DATA_W-1] with cnt = 1.
  - fmt_lj = 0 behaves as standard I2S.
- Undefined: no port; I2S only; logic identical to fmt_lj = 0.

Decomposition:
- Shared package i2s_pkg holds:
  - the state encoding (HUNT, LEFT, RIGHT);
  - the channel constants CH_LEFT = 0 and CH_RIGHT = 1;
  - the default sample width of 16, which the I2S transmitter also uses.
- One natural sub-module, i2s_pin_sync: a SYNC_STAGES synchronizer plus previous-value register, providing a BCK rise strobe, synchronized WS and synchronized DIN.

Test Plan:
- 32-bit slots, BCK = clk/8, left 0x1234, right 0xABCD, out_ready = 1:
  - on the second frame, out_left = 0x1234, out_right = 0xABCD, out_valid pulses 1 clk per frame;
  - the first frame is dropped (HUNT).
- 16-bit slots (32 BCK per frame), LSB on the WS-change edge, values 0x8001 / 0x7FFE:
  - exact capture, no bit slip.
- 8-bit slots, left 0xA5, right 0x3C:
  - out_left = 0xA500, out_right = 0x3C00.
- out_ready = 0 for 3 frames, then 1:
  - the first pair is held;
  - overrun pulses twice;
  - the held pair is delivered, then the next complete frame is delivered.
- WS stuck low for 100 BCK after lock:
  - sync_err pulses once, locked = 0;
  - after WS resumes, relock;
  - the first full frame after relock is discarded, the next is delivered.
- sys_rst_i asserted mid-left-slot:
  - all outputs 0 immediately, no valid;
  - with I2S_RX_LJ_EN and fmt_lj = 1, LJ stream 0x1234 / 0xABCD is captured identically.
